// File: rtl/uart_fifo_tx_param.sv
// UART transmitter with an integrated synchronous FIFO, configurable width, parity and stop bits.
// Optional clear-to-send gating is enabled by defining UART_FIFO_TX_CTS_EN.
module uart_fifo_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_AW      = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int AF_MARGIN    = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] din,
`ifdef UART_FIFO_TX_CTS_EN
    input  logic                 cts_n,
`endif
    output logic                 full,
    output logic                 almost_full,
    output logic                 empty,
    output logic [FIFO_AW:0]     data_count,
    output logic                 overflow,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 tx_serial_data
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] AF_THRESH = (FIFO_AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2 || FIFO_AW < 1) begin : g_bad_param
            $fatal(1, "uart_fifo_tx_param: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     count_next;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    state_t               state, state_next;
    logic [BW-1:0]        baud_cnt, baud_next;
    logic [2:0]           bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par_bit, par_next;
    logic                 baud_last, cts_ok, start_ok;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign push     = wr_en && !full;
    assign head     = mem[rd_ptr];
    assign head_par = (PARITY == 2) ? ^head : ~^head;

    always_comb begin
        count_next = data_count;
        if (push && !pop)
            count_next = data_count + 1'b1;
        else if (pop && !push)
            count_next = data_count - 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_count  <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            data_count  <= count_next;
            empty       <= (count_next == '0);
            full        <= (count_next == DEPTH_C);
            almost_full <= (count_next >= AF_THRESH);
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

`ifdef UART_FIFO_TX_CTS_EN
    logic [1:0] cts_sync;

    always_ff @(posedge clk_in) begin
        if (rst)
            cts_sync <= 2'b11;
        else
            cts_sync <= {cts_sync[0], cts_n};
    end

    assign cts_ok = ~cts_sync[1];
`else
    assign cts_ok = 1'b1;
`endif

    assign start_ok  = tx_en && !empty && cts_ok;
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            par_bit  <= par_next;
        end
    end

    // The final stop cycle may load the next word directly, so frames run with no idle gap.
    always_comb begin
        state_next     = state;
        baud_next      = baud_last ? '0 : baud_cnt + 1'b1;
        bit_next       = bit_cnt;
        shreg_next     = shreg;
        par_next       = par_bit;
        pop            = 1'b0;
        tx_done        = 1'b0;
        tx_serial_data = 1'b1;
        case (state)
            IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                if (start_ok) begin
                    pop        = 1'b1;
                    shreg_next = head;
                    par_next   = head_par;
                    state_next = START;
                end
            end
            START: begin
                tx_serial_data = 1'b0;
                if (baud_last)
                    state_next = DATA;
            end
            DATA: begin
                tx_serial_data = shreg[0];
                if (baud_last) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            PAR: begin
                tx_serial_data = par_bit;
                if (baud_last)
                    state_next = STOP;
            end
            STOP: begin
                if (baud_last) begin
                    if (bit_cnt == STOP_LAST) begin
                        tx_done  = 1'b1;
                        bit_next = '0;
                        if (start_ok) begin
                            pop        = 1'b1;
                            shreg_next = head;
                            par_next   = head_par;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_tx_param.sv
// Testbench for uart_fifo_tx_param: a line monitor decodes frames and checks them against a queue of expected frames.
// Two instances: 8N1 with a 4-deep FIFO, and 7-bit odd parity with two stop bits.
module tb_uart_fifo_tx_param;

    localparam int CPB = 4;

    logic clk_in = 1'b0;
    logic rst;
    logic cts_n;

    logic       tx_en0, wr_en0;
    logic [7:0] din0;
    logic       full0, af0, empty0, ovf0, busy0, done0, line0;
    logic [2:0] count0;

    logic       tx_en1, wr_en1;
    logic [6:0] din1;
    logic       full1, af1, empty1, ovf1, busy1, done1, line1;
    logic [4:0] count1;

    logic [1:0] line_v, done_v;
    assign line_v = {line1, line0};
    assign done_v = {done1, done0};

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;
    int frames_seen0 = 0;
    int frames_seen1 = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    int start_log0[$], done_log0[$], start_log1[$], done_log1[$];

    typedef struct {
        logic [7:0]  din;
        logic [15:0] frame;
    } frame_vec_t;

    typedef struct {
        logic [7:0] din;
        bit         accepted;
        int         count;
        bit         af;
        bit         full;
        bit         ovf;
    } fill_vec_t;

    frame_vec_t frame_vecs[4];
    fill_vec_t  fill_vecs[5];

    uart_fifo_tx_param #(
        .DATA_BITS(8), .FIFO_AW(2), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .AF_MARGIN(2)
    ) u_dut0 (
        .clk_in(clk_in), .rst(rst), .tx_en(tx_en0), .wr_en(wr_en0), .din(din0),
`ifdef UART_FIFO_TX_CTS_EN
        .cts_n(cts_n),
`endif
        .full(full0), .almost_full(af0), .empty(empty0), .data_count(count0),
        .overflow(ovf0), .busy(busy0), .tx_done(done0), .tx_serial_data(line0)
    );

    uart_fifo_tx_param #(
        .DATA_BITS(7), .FIFO_AW(4), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2), .AF_MARGIN(2)
    ) u_dut1 (
        .clk_in(clk_in), .rst(rst), .tx_en(tx_en1), .wr_en(wr_en1), .din(din1),
`ifdef UART_FIFO_TX_CTS_EN
        .cts_n(cts_n),
`endif
        .full(full1), .almost_full(af1), .empty(empty1), .data_count(count1),
        .overflow(ovf1), .busy(busy1), .tx_done(done1), .tx_serial_data(line1)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cycle_no <= cycle_no + 1;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] frame8(input logic [7:0] v);
        return {6'b0, 1'b1, v, 1'b0};
    endfunction

    function automatic logic [15:0] frame7(input logic [6:0] v);
        return {5'b0, 2'b11, ~^v, v, 1'b0};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_in);
    endtask

    task automatic apply_stimulus(input int d, input logic [7:0] v, input bit accepted);
        if (d == 0) begin
            wr_en0 = 1'b1;
            din0   = v;
            if (accepted) exp_q0.push_back(frame8(v));
            step();
            wr_en0 = 1'b0;
        end else begin
            wr_en1 = 1'b1;
            din1   = v[6:0];
            if (accepted) exp_q1.push_back(frame7(v[6:0]));
            step();
            wr_en1 = 1'b0;
        end
    endtask

    task automatic wait_drain(input int d, input int budget);
        int n = 0;
        while (n < budget && ((d == 0) ? (exp_q0.size() != 0 || busy0) : (exp_q1.size() != 0 || busy1))) begin
            step();
            n++;
        end
        check_output("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    // Decodes one frame at a time, requiring every bit to hold for CPB cycles and tx_done only on the last cycle.
    task automatic monitor_line(input int d);
        int nbits, b, start_cyc;
        logic [15:0] bits, expv;
        bit stable_ok, done_ok, aborted;
        nbits = (d == 0) ? 10 : 11;
        forever begin
            @(negedge clk_in);
            if (!rst && line_v[d] == 1'b0) begin
                bits = '0; stable_ok = 1'b1; done_ok = 1'b1; aborted = 1'b0;
                start_cyc = cycle_no;
                for (int cyc = 1; cyc <= nbits * CPB; cyc++) begin
                    if (cyc > 1) @(negedge clk_in);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    b = (cyc - 1) / CPB;
                    if ((cyc - 1) % CPB == 0) bits[b] = line_v[d];
                    else if (line_v[d] !== bits[b]) stable_ok = 1'b0;
                    if (done_v[d] !== (cyc == nbits * CPB)) done_ok = 1'b0;
                end
                if (!aborted) begin
                    if (d == 0) begin
                        frames_seen0++; start_log0.push_back(start_cyc); done_log0.push_back(cycle_no);
                    end else begin
                        frames_seen1++; start_log1.push_back(start_cyc); done_log1.push_back(cycle_no);
                    end
                    if ((d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_frame dut=%0d actual=0x%0h expected=none", d, bits);
                    end else begin
                        expv = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check_output((d == 0) ? "frame_dut0" : "frame_dut1", 32'(bits), 32'(expv));
                        check_output("bit_stable", 32'(stable_ok), 32'd1);
                        check_output("tx_done_pulse", 32'(done_ok), 32'd1);
                    end
                end
            end
        end
    endtask

    initial monitor_line(0);
    initial monitor_line(1);

    initial begin
        int n_before;
        frame_vecs[0] = '{8'h00, 16'h0200};
        frame_vecs[1] = '{8'hFF, 16'h03FE};
        frame_vecs[2] = '{8'h3C, 16'h0278};
        frame_vecs[3] = '{8'h81, 16'h0302};
        fill_vecs[0]  = '{8'h11, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        fill_vecs[1]  = '{8'h22, 1'b1, 2, 1'b1, 1'b0, 1'b0};
        fill_vecs[2]  = '{8'h33, 1'b1, 3, 1'b1, 1'b0, 1'b0};
        fill_vecs[3]  = '{8'h44, 1'b1, 4, 1'b1, 1'b1, 1'b0};
        fill_vecs[4]  = '{8'h55, 1'b0, 4, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; cts_n = 1'b0;
        tx_en0 = 1'b0; wr_en0 = 1'b0; din0 = '0;
        tx_en1 = 1'b0; wr_en1 = 1'b0; din1 = '0;
        step();
        step();
        sample();
        check_output("rst_line", 32'(line0), 32'd1);
        check_output("rst_busy", 32'(busy0), 32'd0);
        check_output("rst_empty", 32'(empty0), 32'd1);
        check_output("rst_full", 32'(full0), 32'd0);
        check_output("rst_almost_full", 32'(af0), 32'd0);
        check_output("rst_overflow", 32'(ovf0), 32'd0);
        check_output("rst_count", 32'(count0), 32'd0);
        check_output("rst_tx_done", 32'(done0), 32'd0);
        check_output("rst_line_dut1", 32'(line1), 32'd1);
        check_output("rst_empty_dut1", 32'(empty1), 32'd1);

        // Single byte 0xA5: start bit on the edge after the push.
        step();
        rst = 1'b0;
        tx_en0 = 1'b1;
        repeat (3) step();
        wr_en0 = 1'b1; din0 = 8'hA5; exp_q0.push_back(16'h034A);
        step();
        wr_en0 = 1'b0;
        sample();
        check_output("lat_empty_k", 32'(empty0), 32'd0);
        check_output("lat_count_k", 32'(count0), 32'd1);
        check_output("lat_line_k", 32'(line0), 32'd1);
        step();
        sample();
        check_output("lat_line_k1", 32'(line0), 32'd0);
        check_output("lat_busy_k1", 32'(busy0), 32'd1);
        check_output("lat_count_k1", 32'(count0), 32'd0);
        wait_drain(0, 200);
        check_output("a5_frame_len", 32'(done_log0[$] - start_log0[$]), 32'd39);
        check_output("a5_busy_after", 32'(busy0), 32'd0);

        for (int i = 0; i < 4; i++) begin
            wr_en0 = 1'b1; din0 = frame_vecs[i].din; exp_q0.push_back(frame_vecs[i].frame);
            step();
            wr_en0 = 1'b0;
            wait_drain(0, 200);
            check_output("table_frame_len", 32'(done_log0[$] - start_log0[$]), 32'd39);
        end

        // Back-to-back: queue three words while held off, then release.
        tx_en0 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(0, 8'(i), 1'b1);
            sample();
            check_output("b2b_fill_count", 32'(count0), 32'(i));
        end
        n_before = start_log0.size();
        tx_en0 = 1'b1;
        step();
        sample();
        check_output("b2b_count_first_pop", 32'(count0), 32'd2);
        check_output("b2b_line_start", 32'(line0), 32'd0);
        repeat (40) step();
        sample();
        check_output("b2b_count_second_pop", 32'(count0), 32'd1);
        wait_drain(0, 400);
        check_output("b2b_frames", 32'(start_log0.size() - n_before), 32'd3);
        if (start_log0.size() - n_before == 3) begin
            check_output("b2b_gap1", 32'(start_log0[n_before+1] - start_log0[n_before]), 32'd40);
            check_output("b2b_gap2", 32'(start_log0[n_before+2] - start_log0[n_before+1]), 32'd40);
        end

        // Overflow on the 4-deep FIFO with transmission held off.
        tx_en0 = 1'b0;
        n_before = frames_seen0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, fill_vecs[i].din, fill_vecs[i].accepted);
            sample();
            check_output("fill_count", 32'(count0), 32'(fill_vecs[i].count));
            check_output("fill_almost_full", 32'(af0), 32'(fill_vecs[i].af));
            check_output("fill_full", 32'(full0), 32'(fill_vecs[i].full));
            check_output("fill_overflow", 32'(ovf0), 32'(fill_vecs[i].ovf));
        end
        tx_en0 = 1'b1;
        wait_drain(0, 800);
        repeat (20) step();
        check_output("ovf_frames_sent", 32'(frames_seen0 - n_before), 32'd4);
        check_output("ovf_sticky", 32'(ovf0), 32'd1);
        check_output("ovf_empty_after", 32'(empty0), 32'd1);

        // Reset during data bit 3 of a frame with a second word still queued.
        apply_stimulus(0, 8'h5A, 1'b1);
        apply_stimulus(0, 8'h77, 1'b1);
        repeat (17) step();
        rst = 1'b1;
        exp_q0.delete();
        n_before = frames_seen0;
        step();
        rst = 1'b0;
        sample();
        check_output("midrst_line", 32'(line0), 32'd1);
        check_output("midrst_busy", 32'(busy0), 32'd0);
        check_output("midrst_empty", 32'(empty0), 32'd1);
        check_output("midrst_count", 32'(count0), 32'd0);
        check_output("midrst_overflow", 32'(ovf0), 32'd0);
        repeat (100) step();
        check_output("midrst_no_frames", 32'(frames_seen0 - n_before), 32'd0);
        check_output("midrst_line_idle", 32'(line0), 32'd1);

        // Odd parity, 7 data bits, 2 stop bits.
        tx_en1 = 1'b1;
        wr_en1 = 1'b1; din1 = 7'h55; exp_q1.push_back(16'h07AA);
        step();
        wr_en1 = 1'b0;
        wait_drain(1, 300);
        check_output("par_frame_len", 32'(done_log1[$] - start_log1[$]), 32'd43);
        apply_stimulus(1, 8'h03, 1'b1);
        apply_stimulus(1, 8'h07, 1'b1);
        wait_drain(1, 400);
        check_output("par_frames", 32'(frames_seen1), 32'd3);

`ifdef UART_FIFO_TX_CTS_EN
        cts_n = 1'b1;
        repeat (3) step();
        wr_en0 = 1'b1; din0 = 8'h3C; exp_q0.push_back(16'h0278);
        step();
        wr_en0 = 1'b0;
        repeat (8) step();
        sample();
        check_output("cts_held_line", 32'(line0), 32'd1);
        check_output("cts_held_count", 32'(count0), 32'd1);
        cts_n = 1'b0;
        step();
        sample();
        check_output("cts_sync1_line", 32'(line0), 32'd1);
        step();
        sample();
        check_output("cts_sync2_line", 32'(line0), 32'd1);
        step();
        sample();
        check_output("cts_start_line", 32'(line0), 32'd0);
        wait_drain(0, 200);
`endif

        repeat (10) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
